// File: rtl/pix_pkg.sv
// -----------------------------------------------------------------------------
// pix_pkg
// Shared definitions for the pixel neighbourhood pipeline: default pixel
// width, window-generator state encoding and the names of the eight
// neighbour positions around a centre pixel.
// No ports (package).
// -----------------------------------------------------------------------------
package pix_pkg;

   localparam int PIX_W_DEF = 8;

   // FILL : priming the line buffers, no windows yet
   // RUN  : one window per accepted pixel
   // FLUSH: draining the last IMG_W+1 windows with no input
   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Neighbour positions, raster order around the centre:
   //   A B C
   //   D . E
   //   F G H
   typedef enum logic [2:0] {
      NB_A = 3'd0,
      NB_B = 3'd1,
      NB_C = 3'd2,
      NB_D = 3'd3,
      NB_E = 3'd4,
      NB_F = 3'd5,
      NB_G = 3'd6,
      NB_H = 3'd7
   } nb_e;

   localparam int NB_NUM = 8;

endpackage

// File: rtl/line_buf.sv
// -----------------------------------------------------------------------------
// line_buf
// Fixed-length delay line of DEPTH entries. Each enabled cycle the entry at
// the pointer is presented on dout (the value written DEPTH enables ago) and
// then overwritten by din.
// Ports:
//   clk, rst  clock and synchronous active-high reset (pointer only)
//   en        advance the delay line by one position
//   din       value entering the line
//   dout      value leaving the line (combinational from the storage)
// -----------------------------------------------------------------------------
module line_buf #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ptr_q, ptr_d;

   // Read-before-write: dout shows the old contents of the slot that din
   // replaces on this enable.
   assign dout = mem[ptr_q];

   // NOTE: every variable assigned in an always_comb gets a value on every
   // path (here via the default first) so no latch is inferred.
   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; stale contents are
   // never used, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr_q] <= din;
      end
   end

endmodule

// File: rtl/pix_window_gen.sv
// -----------------------------------------------------------------------------
// pix_window_gen
// Streaming 3x3 neighbourhood generator. Accepts a raster-order pixel stream
// and emits one registered window per frame pixel: centre `orig` plus the
// eight neighbours a..h, with out-of-frame neighbours replaced by the centre.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pix_in/pix_valid/pix_ready   input pixel stream (valid/ready)
//   a..h, orig               window outputs (registered)
//   win_valid/win_ready      window handshake
//   win_last                 window centred on (IMG_H-1, IMG_W-1)
// -----------------------------------------------------------------------------
module pix_window_gen
   import pix_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [PIX_W-1:0] a,
   output logic [PIX_W-1:0] b,
   output logic [PIX_W-1:0] c,
   output logic [PIX_W-1:0] d,
   output logic [PIX_W-1:0] e,
   output logic [PIX_W-1:0] f,
   output logic [PIX_W-1:0] g,
   output logic [PIX_W-1:0] h,
   output logic [PIX_W-1:0] orig,
   output logic             win_valid,
   input  logic             win_ready,
   output logic             win_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int NW = $clog2(IMG_W * IMG_H);

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [NW-1:0] FILL_LAST = NW'(IMG_W);
   localparam logic [NW-1:0] PIX_LAST  = NW'(IMG_W * IMG_H - 1);

   state_e           state_q, state_d;
   logic [NW-1:0]    in_cnt_q, in_cnt_d;     // index of next input pixel
   logic [CW-1:0]    cen_col_q, cen_col_d;   // centre of next window
   logic [RW-1:0]    cen_row_q, cen_row_d;

   // Column shift registers: index 0 holds column k-1, index 1 column k-2,
   // where k is the column entering on the current step.
   logic [PIX_W-1:0] top_sr_q [2], top_sr_d [2];
   logic [PIX_W-1:0] mid_sr_q [2], mid_sr_d [2];
   logic [PIX_W-1:0] bot_sr_q [2], bot_sr_d [2];

   logic [PIX_W-1:0] nb_q [NB_NUM], nb_d [NB_NUM];
   logic [PIX_W-1:0] orig_q, orig_d;
   logic             win_valid_q, win_valid_d;
   logic             win_last_q, win_last_d;

   logic [PIX_W-1:0] mid_in, top_in;
   logic [PIX_W-1:0] raw [NB_NUM];
   logic [PIX_W-1:0] sel [NB_NUM];
   logic [PIX_W-1:0] centre;
   logic             slot_free, in_xfer, step, emit, cen_last;

   // ---------------------------------------------------------------------
   // Handshake and step qualification
   // ---------------------------------------------------------------------
   assign slot_free = !win_valid_q || win_ready;
   assign pix_ready = !rst && (state_q != FLUSH) && slot_free;
   assign in_xfer   = pix_valid && pix_ready;
   assign step      = in_xfer || ((state_q == FLUSH) && slot_free);
   assign emit      = step && (state_q != FILL);
   assign cen_last  = (cen_col_q == COL_LAST) && (cen_row_q == ROW_LAST);

   // ---------------------------------------------------------------------
   // Line buffers: mid_in is pixel k-IMG_W, top_in is pixel k-2*IMG_W.
   // They keep advancing during FLUSH; the junk shifted in then only ever
   // lands on positions the border rule replaces.
   // ---------------------------------------------------------------------
   line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
      .clk  (clk),
      .rst  (rst),
      .en   (step),
      .din  (pix_in),
      .dout (mid_in)
   );

   line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
      .clk  (clk),
      .rst  (rst),
      .en   (step),
      .din  (mid_in),
      .dout (top_in)
   );

   // ---------------------------------------------------------------------
   // Window assembly: the window completed on a step is centred on column
   // k-1 of the middle row, so the incoming column supplies c/e/h.
   // ---------------------------------------------------------------------
   always_comb begin
      centre   = mid_sr_q[0];
      raw[NB_A] = top_sr_q[1];
      raw[NB_B] = top_sr_q[0];
      raw[NB_C] = top_in;
      raw[NB_D] = mid_sr_q[1];
      raw[NB_E] = mid_in;
      raw[NB_F] = bot_sr_q[1];
      raw[NB_G] = bot_sr_q[0];
      raw[NB_H] = pix_in;

      sel = raw;
      // Edge replication; this also masks wrap-around from adjacent rows
      // and any stale line-buffer contents from a previous frame.
      if (cen_row_q == '0) begin
         sel[NB_A] = centre;
         sel[NB_B] = centre;
         sel[NB_C] = centre;
      end
      if (cen_row_q == ROW_LAST) begin
         sel[NB_F] = centre;
         sel[NB_G] = centre;
         sel[NB_H] = centre;
      end
      if (cen_col_q == '0) begin
         sel[NB_A] = centre;
         sel[NB_D] = centre;
         sel[NB_F] = centre;
      end
      if (cen_col_q == COL_LAST) begin
         sel[NB_C] = centre;
         sel[NB_E] = centre;
         sel[NB_H] = centre;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state: FSM, counters, shift registers and output window
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      cen_col_d   = cen_col_q;
      cen_row_d   = cen_row_q;
      top_sr_d    = top_sr_q;
      mid_sr_d    = mid_sr_q;
      bot_sr_d    = bot_sr_q;
      nb_d        = nb_q;
      orig_d      = orig_q;
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;

      if (in_xfer) begin
         in_cnt_d = (in_cnt_q == PIX_LAST) ? '0 : in_cnt_q + 1'b1;
      end

      unique case (state_q)
         FILL:    if (in_xfer && (in_cnt_q == FILL_LAST)) state_d = RUN;
         RUN:     if (in_xfer && (in_cnt_q == PIX_LAST))  state_d = FLUSH;
         FLUSH:   if (step && cen_last)                   state_d = FILL;
         default: state_d = FILL;
      endcase

      if (step) begin
         top_sr_d[1] = top_sr_q[0];
         mid_sr_d[1] = mid_sr_q[0];
         bot_sr_d[1] = bot_sr_q[0];
         top_sr_d[0] = top_in;
         mid_sr_d[0] = mid_in;
         bot_sr_d[0] = pix_in;
      end

      if (emit) begin
         nb_d        = sel;
         orig_d      = centre;
         win_valid_d = 1'b1;
         win_last_d  = cen_last;
         if (cen_col_q == COL_LAST) begin
            cen_col_d = '0;
            cen_row_d = (cen_row_q == ROW_LAST) ? '0 : cen_row_q + 1'b1;
         end else begin
            cen_col_d = cen_col_q + 1'b1;
         end
      end else if (win_ready) begin
         // Window consumed with nothing new behind it; data simply holds.
         win_valid_d = 1'b0;
         win_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         in_cnt_q    <= '0;
         cen_col_q   <= '0;
         cen_row_q   <= '0;
         top_sr_q    <= '{default: '0};
         mid_sr_q    <= '{default: '0};
         bot_sr_q    <= '{default: '0};
         nb_q        <= '{default: '0};
         orig_q      <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         cen_col_q   <= cen_col_d;
         cen_row_q   <= cen_row_d;
         top_sr_q    <= top_sr_d;
         mid_sr_q    <= mid_sr_d;
         bot_sr_q    <= bot_sr_d;
         nb_q        <= nb_d;
         orig_q      <= orig_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
      end
   end

   assign a         = nb_q[NB_A];
   assign b         = nb_q[NB_B];
   assign c         = nb_q[NB_C];
   assign d         = nb_q[NB_D];
   assign e         = nb_q[NB_E];
   assign f         = nb_q[NB_F];
   assign g         = nb_q[NB_G];
   assign h         = nb_q[NB_H];
   assign orig      = orig_q;
   assign win_valid = win_valid_q;
   assign win_last  = win_last_q;

endmodule

// File: tb/tb_pix_window_gen.sv
// -----------------------------------------------------------------------------
// tb_pix_window_gen
// Directed bench for pix_window_gen on a 4x3 frame. Pixels are offered from a
// queue, expected windows (from an edge-replication reference) are queued
// alongside, and every cycle with a visible window is compared against the
// head of that queue. Hand-computed windows pin down the reference itself.
// -----------------------------------------------------------------------------
module tb_pix_window_gen;

   localparam int TW = 4;
   localparam int TH = 3;
   localparam int PW = 8;
   localparam int BUDGET = 400;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic [PW-1:0] a, b, c, d, e, f, g, h, orig;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic          win_last;

   int n_vec = 0;
   int n_err = 0;

   logic [PW-1:0] px_q [$];
   logic [72:0]   exp_q [$];
   logic [72:0]   cap_q [$];

   pix_window_gen #(.IMG_W(TW), .IMG_H(TH), .PIX_W(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .e         (e),
      .f         (f),
      .g         (g),
      .h         (h),
      .orig      (orig),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_last  (win_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {last, orig, a, b, c, d, e, f, g, h}
   function automatic logic [72:0] win_now();
      return {win_last, orig, a, b, c, d, e, f, g, h};
   endfunction

   function automatic logic [72:0] hw(input logic l, input int o, input int pa, input int pb,
                                      input int pc, input int pd, input int pe, input int pf,
                                      input int pg, input int ph);
      return {l, 8'(o), 8'(pa), 8'(pb), 8'(pc), 8'(pd), 8'(pe), 8'(pf), 8'(pg), 8'(ph)};
   endfunction

   // Reference: frame pixel at index i is base+i; out-of-frame -> centre.
   function automatic logic [72:0] model_win(input int base, input int idx);
      logic [7:0] v [9];
      int r, col, rr, cc, k;
      r   = idx / TW;
      col = idx % TW;
      k   = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = col + dc;
            if (rr < 0 || rr >= TH || cc < 0 || cc >= TW) v[k] = 8'(base + idx);
            else                                          v[k] = 8'(base + rr * TW + cc);
            k++;
         end
      end
      return {(idx == TW * TH - 1), v[4], v[0], v[1], v[2], v[3], v[5], v[6], v[7], v[8]};
   endfunction

   task automatic push_frame(input int base);
      for (int i = 0; i < TW * TH; i++) begin
         px_q.push_back(8'(base + i));
         exp_q.push_back(model_win(base, i));
      end
   endtask

   // mode 0: win_ready high; 1: win_ready toggles; 2: 5-cycle stall in RUN.
   // Called at (or just after) a falling edge; returns at a falling edge.
   task automatic run_traffic(input int mode);
      int  cyc = 0;
      int  stall_left = 0;
      bit  stalled = 1'b0;
      int  acc = 0;
      int  got = 0;
      bit  rdy;
      while ((px_q.size() > 0 || exp_q.size() > 0) && cyc < BUDGET) begin
         if (mode == 2 && !stalled && got == 2) begin
            stall_left = 5;
            stalled    = 1'b1;
         end
         if (mode == 1) rdy = (cyc % 2 == 1);
         else           rdy = (stall_left == 0);
         pix_valid = (px_q.size() > 0);
         pix_in    = (px_q.size() > 0) ? px_q[0] : '0;
         win_ready = rdy;
         #1;
         if (win_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_win", 73'(win_valid), '0);
            end else begin
               check("win", win_now(), exp_q[0]);
               if (!win_ready) check("stall_pix_ready", 73'(pix_ready), '0);
               if (win_ready) begin
                  cap_q.push_back(win_now());
                  void'(exp_q.pop_front());
                  got++;
               end
            end
         end
         // Between the last input of a frame and its final FLUSH step.
         if (acc > 0 && acc % (TW * TH) == 0 && (acc - got) > 1)
            check("flush_pix_ready", 73'(pix_ready), '0);
         if (pix_valid && pix_ready) begin
            void'(px_q.pop_front());
            acc++;
         end
         if (stall_left > 0) stall_left--;
         cyc++;
         @(negedge clk);
      end
      if (cyc >= BUDGET) check("timeout", 73'(px_q.size() + exp_q.size()), '0);
      px_q.delete();
      exp_q.delete();
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_win", win_now(), '0);
      check("rst_valid", 73'(win_valid), '0);
      check("rst_pix_ready", 73'(pix_ready), '0);
      @(negedge clk);
      rst = 1'b0;

      // Ramp frame, free-flowing output
      cap_q.delete();
      push_frame(0);
      run_traffic(0);
      check("ramp_count", 73'(cap_q.size()), 73'(12));
      if (cap_q.size() == 12) begin
         check("corner", cap_q[0], hw(0, 0, 0, 0, 0, 0, 1, 0, 4, 5));
         check("right_edge", cap_q[3], hw(0, 3, 3, 3, 3, 2, 3, 6, 7, 3));
         check("interior", cap_q[5], hw(0, 5, 0, 1, 2, 4, 6, 8, 9, 10));
         check("last", cap_q[11], hw(1, 11, 6, 7, 11, 10, 11, 11, 11, 11));
      end

      // Five-cycle stall during RUN
      cap_q.delete();
      push_frame(0);
      run_traffic(2);
      check("stall_count", 73'(cap_q.size()), 73'(12));

      // win_ready toggling every cycle
      cap_q.delete();
      push_frame(0);
      run_traffic(1);
      check("toggle_count", 73'(cap_q.size()), 73'(12));

      // Partial frame through pixel 7, then reset
      cap_q.delete();
      for (int i = 0; i < 8; i++) px_q.push_back(8'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(model_win(0, i));
      run_traffic(0);
      check("partial_count", 73'(cap_q.size()), 73'(3));
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_win", win_now(), '0);
      check("midrst_valid", 73'(win_valid), '0);
      check("midrst_pix_ready", 73'(pix_ready), '0);
      rst = 1'b0;

      // Back-to-back frames 100..111 and 200..211
      cap_q.delete();
      push_frame(100);
      push_frame(200);
      run_traffic(0);
      check("b2b_count", 73'(cap_q.size()), 73'(24));
      if (cap_q.size() == 24) begin
         check("f1_first", cap_q[0], hw(0, 100, 100, 100, 100, 100, 101, 100, 104, 105));
         check("f2_first", cap_q[12], hw(0, 200, 200, 200, 200, 200, 201, 200, 204, 205));
         check("f2_last", cap_q[23], hw(1, 211, 206, 207, 211, 210, 211, 211, 211, 211));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pix_window_gen.md
# pix_window_gen

Streaming 3x3 neighbourhood generator that feeds the pixel averager. It accepts a raster-order pixel stream one pixel per handshake. For every pixel of the frame, it emits one registered window: the centre pixel `orig` and its eight neighbours `a`..`h`, with out-of-frame neighbours replaced by the centre value. It sits between the frame source and `avg_pix`; its window outputs connect directly to the averager's inputs of the same names.

## Interface
- `IMG_W`, default 640: frame width in pixels, must be >= 2.
- `IMG_H`, default 480: frame height in pixels, must be >= 2.
- `PIX_W`, default 8: bits per pixel.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pix_in`  in  PIX_W  input pixel, raster order (row 0 first, column 0 first).
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  block accepts `pix_in` this cycle.
- `a`,`b`,`c`  out  PIX_W each  neighbours at top-left, top and top-right.
- `d`,`e`  out  PIX_W each  neighbours at left and right.
- `f`,`g`,`h`  out  PIX_W each  neighbours at bottom-left, bottom and bottom-right.
- `orig`  out  PIX_W  centre pixel.
- `win_valid`  out  1  window outputs are valid.
- `win_ready`  in  1  downstream consumes the window this cycle.
- `win_last`  out  1  the current window is the frame's final window, centre (IMG_H-1, IMG_W-1).

## Operation
- Transfers:
  - An input transfer occurs when `pix_valid` and `pix_ready` are both high.
  - An output transfer occurs when `win_valid` and `win_ready` are both high.
- Slot free: `slot_free = !win_valid || win_ready`.
- Step: the window pipeline advances by one step on an input transfer, or on a FLUSH cycle with `slot_free` high.
- States:
  - FILL: accepts the first IMG_W+1 pixels of the frame and emits no windows. After pixel index IMG_W is accepted, go to RUN.
  - RUN: each accepted pixel produces one window. The window centre lags the input by IMG_W+1 pixels. After the final frame pixel (index IMG_W*IMG_H-1) is accepted, go to FLUSH.
  - FLUSH: `pix_ready`=0. Emits the remaining IMG_W+1 windows, one per step, with no input. The final window drives `win_last`=1. On its step, go to FILL for the next frame.
- `pix_ready` = `!rst && state != FLUSH && slot_free`.
- Storage:
  - Two line buffers of IMG_W entries hold rows r-1 and r.
  - A 3x3 shift register holds columns c-1..c+1.
  - Centre row and column counters drive border selection.
- Border rule (edge replication): any neighbour position outside the frame outputs `orig`.
  - Row 0: `a`,`b`,`c` are replaced.
  - Row IMG_H-1: `f`,`g`,`h` are replaced.
  - Column 0: `a`,`d`,`f` are replaced.
  - Column IMG_W-1: `c`,`e`,`h` are replaced.
  - Corners combine the applicable row and column rules.
  - Wrap-around from the previous or next row must never appear in the outputs.
- Exactly IMG_W*IMG_H windows are emitted per frame, each appearing exactly once.
- No arithmetic on pixel values; all data paths are PIX_W wide.

## Timing
- Reset values:
  - `win_valid`=0, `win_last`=0, `a`..`h`=0, `orig`=0.
  - `pix_ready`=0 while `rst` is high.
  - State = FILL; all counters = 0.
- Reset mid-frame discards the partial frame. The first pixel accepted after reset is treated as pixel (0,0).
- Latency: a window is registered and appears in the cycle after the step that completes it.
  - The first window (centre (0,0)) appears the cycle after pixel index IMG_W+1 is accepted.
- Throughput: one window per cycle in RUN and FLUSH when `win_ready` is held high.
  - In RUN, an output transfer and an input transfer in the same cycle are both legal; the next window appears in the following cycle.
- Backpressure: while `win_valid`=1 and `win_ready`=0, all window outputs and `win_last` hold stable, `pix_ready`=0, and no state changes.
- Back-to-back frames: the first pixel of the next frame is accepted no earlier than the cycle after the final FLUSH step.

## Structure
- Shared package `pix_pkg`:
  - default `PIX_W`
  - state encoding `FILL`/`RUN`/`FLUSH`
  - neighbour position names
- Sub-module `line_buf`: IMG_W x PIX_W delay line with a read-before-write of the same address, advanced by a single enable. Instantiate it twice.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, and feed a ramp of pixels 0..11 unless stated otherwise.
- Corner window: window 1 is centre 0 with `a`,`b`,`c`,`d`,`f`=0, `e`=1, `g`=4, `h`=5, `win_last`=0.
- Interior window: window 6 is centre 5 with `a`=0, `b`=1, `c`=2, `d`=4, `e`=6, `f`=8, `g`=9, `h`=10.
- Right-edge window: the centre-3 window has `c`=`e`=`h`=3 (no wrap to value 4), `b`=3, `a`=3, `d`=2, `f`=6, `g`=7.
- Flush and last: after pixel 11 is accepted, `pix_ready`=0 and 5 more windows follow. The last window has centre 11 with `a`=6, `b`=7, `d`=10, all others 11, and `win_last`=1. The total count is 12.
- Backpressure:
  - Drop `win_ready` for 5 cycles during RUN: outputs stay frozen, `pix_ready`=0, and the sequence resumes with no loss or duplication.
  - `win_ready` toggling every cycle yields an identical window sequence.
- Reset and back-to-back:
  - Assert `rst` after pixel 7: outputs go to 0 the next cycle.
  - Then stream frame 100..111 immediately followed by 200..211: two correct 12-window sequences, with the first window of the second frame centred on 200.
